// File: rtl/writeback_unit_pkg.sv
// Shared decode definitions for the writeback stage: default data width,
// load funct3 encodings and the arbiter grant type.
package writeback_unit_pkg;

  localparam int DEF_XLEN = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } load_f3_e;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Combinational load extraction: selects the byte/halfword/word addressed by
// offset from the aligned memory word, extends it, and flags illegal/misaligned loads.
module load_align
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [4:0]  byte_lsb;
  logic [4:0]  half_lsb;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_lsb = {offset, 3'b000};
  assign half_lsb = {offset[1], 4'b0000};
  assign byte_val = rdata[byte_lsb +: 8];
  assign half_val = rdata[half_lsb +: 16];

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_val};
      F3_LH: begin
        data = {{(XLEN-16){half_val[15]}}, half_val};
        err  = offset[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, half_val};
        err  = offset[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (offset != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: round-robin between ALU and load results, one registered
// register-file write per cycle, plus load error pulse and committed-write counter.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [4:0]      i_lsu_rd,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [1:0]      i_lsu_offset,
  input  logic [XLEN-1:0] i_lsu_rdata,
  output logic            o_rd_wvalid,
  output logic [4:0]      o_rd_waddr,
  output logic [XLEN-1:0] o_rd_wdata,
  output logic            o_load_err,
  output logic [31:0]     o_wb_count
);

  grant_e          last_grant;
  logic            alu_fire;
  logic            lsu_fire;
  logic [XLEN-1:0] ld_data;
  logic            ld_err;

  logic            commit;
  logic            err_next;
  logic [4:0]      waddr_next;
  logic [XLEN-1:0] wdata_next;

  logic            rd_wvalid;
  logic [4:0]      rd_waddr;
  logic [XLEN-1:0] rd_wdata;
  logic            load_err;
  logic [31:0]     wb_count;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (i_lsu_funct3),
    .offset (i_lsu_offset),
    .rdata  (i_lsu_rdata),
    .data   (ld_data),
    .err    (ld_err)
  );

  // When both sources are valid exactly one ready is high, so the fires never overlap.
  assign o_alu_ready = !i_lsu_valid || (last_grant == GNT_LSU);
  assign o_lsu_ready = !i_alu_valid || (last_grant == GNT_ALU);
  assign alu_fire    = i_alu_valid && o_alu_ready;
  assign lsu_fire    = i_lsu_valid && o_lsu_ready;

  always_comb begin
    commit     = 1'b0;
    err_next   = 1'b0;
    waddr_next = i_alu_rd;
    wdata_next = i_alu_data;
    if (alu_fire) begin
      commit = (i_alu_rd != 5'd0);
    end else if (lsu_fire) begin
      err_next   = ld_err;
      commit     = (i_lsu_rd != 5'd0) && !ld_err;
      waddr_next = i_lsu_rd;
      wdata_next = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_wvalid  <= 1'b0;
      rd_waddr   <= 5'd0;
      rd_wdata   <= '0;
      load_err   <= 1'b0;
      wb_count   <= 32'd0;
      last_grant <= GNT_LSU;
    end else begin
      rd_wvalid <= commit;
      load_err  <= err_next;
      if (commit) begin
        rd_waddr <= waddr_next;
        rd_wdata <= wdata_next;
        wb_count <= wb_count + 32'd1;
      end
      if (alu_fire) begin
        last_grant <= GNT_ALU;
      end else if (lsu_fire) begin
        last_grant <= GNT_LSU;
      end
    end
  end

  assign o_rd_wvalid = rd_wvalid;
  assign o_rd_waddr  = rd_waddr;
  assign o_rd_wdata  = rd_wdata;
  assign o_load_err  = load_err;
  assign o_wb_count  = wb_count;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: handshake, arbitration, load alignment,
// error handling, counter wrap and mid-operation reset.
module tb_writeback_unit;

  logic        clk;
  logic        rstn;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [2:0]  i_lsu_funct3;
  logic [1:0]  i_lsu_offset;
  logic [31:0] i_lsu_rdata;
  logic        o_rd_wvalid;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
  logic        o_load_err;
  logic [31:0] o_wb_count;

  int n_checks = 0;
  int n_pass   = 0;

  writeback_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_alu_valid  (i_alu_valid),
    .o_alu_ready  (o_alu_ready),
    .i_alu_rd     (i_alu_rd),
    .i_alu_data   (i_alu_data),
    .i_lsu_valid  (i_lsu_valid),
    .o_lsu_ready  (o_lsu_ready),
    .i_lsu_rd     (i_lsu_rd),
    .i_lsu_funct3 (i_lsu_funct3),
    .i_lsu_offset (i_lsu_offset),
    .i_lsu_rdata  (i_lsu_rdata),
    .o_rd_wvalid  (o_rd_wvalid),
    .o_rd_waddr   (o_rd_waddr),
    .o_rd_wdata   (o_rd_wdata),
    .o_load_err   (o_load_err),
    .o_wb_count   (o_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    i_alu_valid  = 1'b0;
    i_alu_rd     = 5'd0;
    i_alu_data   = 32'd0;
    i_lsu_valid  = 1'b0;
    i_lsu_rd     = 5'd0;
    i_lsu_funct3 = 3'd2;
    i_lsu_offset = 2'd0;
    i_lsu_rdata  = 32'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Issue one load at a negedge, let it transfer, sample the result one cycle later.
  task automatic do_load(input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [4:0] rd);
    i_lsu_valid  = 1'b1;
    i_lsu_rd     = rd;
    i_lsu_funct3 = f3;
    i_lsu_offset = off;
    i_lsu_rdata  = rdata;
    @(posedge clk);
    @(negedge clk);
    i_lsu_valid = 1'b0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] data);
    i_alu_valid = 1'b1;
    i_alu_rd    = rd;
    i_alu_data  = data;
    @(posedge clk);
    @(negedge clk);
    i_alu_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    #2;
    check("rst_wvalid", {31'd0, o_rd_wvalid}, 32'd0);
    check("rst_waddr",  {27'd0, o_rd_waddr},  32'd0);
    check("rst_wdata",  o_rd_wdata,           32'd0);
    check("rst_err",    {31'd0, o_load_err},  32'd0);
    check("rst_count",  o_wb_count,           32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single ALU write
    @(negedge clk);
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1234;
    #1 check("alu_ready_solo", {31'd0, o_alu_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_alu_valid = 1'b0;
    check("alu_wvalid", {31'd0, o_rd_wvalid}, 32'd1);
    check("alu_waddr",  {27'd0, o_rd_waddr},  32'd5);
    check("alu_wdata",  o_rd_wdata,           32'h1234);
    check("alu_count",  o_wb_count,           32'd1);
    @(negedge clk);
    check("idle_wvalid", {31'd0, o_rd_wvalid}, 32'd0);
    check("hold_waddr",  {27'd0, o_rd_waddr},  32'd5);
    check("hold_wdata",  o_rd_wdata,           32'h1234);

    // Contested arbitration right after reset
    apply_reset();
    i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'hAAAA_0001;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd2; i_lsu_funct3 = 3'd2;
    i_lsu_offset = 2'd0; i_lsu_rdata = 32'hBBBB_0002;
    #1;
    check("arb1_alu_rdy", {31'd0, o_alu_ready}, 32'd1);
    check("arb1_lsu_rdy", {31'd0, o_lsu_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("arb2_alu_rdy", {31'd0, o_alu_ready}, 32'd0);
    check("arb2_lsu_rdy", {31'd0, o_lsu_ready}, 32'd1);
    check("arb_w1_addr",  {27'd0, o_rd_waddr},  32'd1);
    check("arb_w1_data",  o_rd_wdata,           32'hAAAA_0001);
    @(posedge clk);
    @(negedge clk);
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    check("arb_w2_vld",   {31'd0, o_rd_wvalid}, 32'd1);
    check("arb_w2_addr",  {27'd0, o_rd_waddr},  32'd2);
    check("arb_w2_data",  o_rd_wdata,           32'hBBBB_0002);
    check("arb_count",    o_wb_count,           32'd2);

    // Load alignment and extension
    do_load(3'd0, 2'd3, 32'h80FF_FFFF, 5'd10);
    check("lb_data",  o_rd_wdata, 32'hFFFF_FF80);
    do_load(3'd4, 2'd3, 32'h80FF_FFFF, 5'd11);
    check("lbu_data", o_rd_wdata, 32'h0000_0080);
    do_load(3'd5, 2'd2, 32'hBEEF_0000, 5'd12);
    check("lhu_data", o_rd_wdata, 32'h0000_BEEF);
    check("lhu_addr", {27'd0, o_rd_waddr}, 32'd12);
    do_load(3'd1, 2'd0, 32'h1234_8001, 5'd13);
    check("lh_data",  o_rd_wdata, 32'hFFFF_8001);
    do_load(3'd0, 2'd1, 32'h0000_7F00, 5'd14);
    check("lb_pos",   o_rd_wdata, 32'h0000_007F);
    check("load_count", o_wb_count, 32'd7);

    // Illegal and misaligned loads
    do_load(3'd2, 2'd1, 32'hDEAD_BEEF, 5'd15);
    check("lw_mis_err",   {31'd0, o_load_err},  32'd1);
    check("lw_mis_wvld",  {31'd0, o_rd_wvalid}, 32'd0);
    check("lw_mis_count", o_wb_count,           32'd7);
    @(negedge clk);
    check("err_pulse_end", {31'd0, o_load_err}, 32'd0);
    do_load(3'd3, 2'd0, 32'hDEAD_BEEF, 5'd15);
    check("f3_bad_err",   {31'd0, o_load_err},  32'd1);
    check("f3_bad_wvld",  {31'd0, o_rd_wvalid}, 32'd0);
    do_load(3'd1, 2'd3, 32'hDEAD_BEEF, 5'd15);
    check("lh_mis_err",   {31'd0, o_load_err},  32'd1);
    check("lh_mis_count", o_wb_count,           32'd7);
    check("err_hold_data", o_rd_wdata,          32'h0000_007F);

    // rd==0 completes the handshake without writing
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h5555_5555;
    #1 check("rd0_ready", {31'd0, o_alu_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_alu_valid = 1'b0;
    check("rd0_wvld",  {31'd0, o_rd_wvalid}, 32'd0);
    check("rd0_count", o_wb_count,           32'd7);

    // Counter wrap
    force dut.wb_count = 32'hFFFF_FFFF;
    #1 release dut.wb_count;
    do_alu(5'd9, 32'h9999_0000);
    check("wrap_wvld",  {31'd0, o_rd_wvalid}, 32'd1);
    check("wrap_count", o_wb_count,           32'd0);

    // Reset in the cycle after a transfer
    @(negedge clk);
    i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h77;
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mrst_wvld",  {31'd0, o_rd_wvalid}, 32'd0);
    check("mrst_count", o_wb_count,           32'd0);
    check("mrst_waddr", {27'd0, o_rd_waddr},  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    i_alu_valid = 1'b1; i_alu_rd = 5'd8; i_alu_data = 32'h88;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd9; i_lsu_funct3 = 3'd2;
    i_lsu_offset = 2'd0; i_lsu_rdata = 32'h99;
    #1;
    check("mrst_alu_rdy", {31'd0, o_alu_ready}, 32'd1);
    check("mrst_lsu_rdy", {31'd0, o_lsu_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    check("mrst_w_addr", {27'd0, o_rd_waddr}, 32'd8);
    check("mrst_w_cnt",  o_wb_count,          32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
